// File: rtl/gon_glb_writer.sv
// Drains the global-output-network psum stream into GLB SRAM at base + n*stride,
// either overwriting or accumulating (read-modify-write) into the stored value.
module gon_glb_writer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic              cfg_acc,
  input  logic              gon_valid,
  output logic              gon_ready,
  input  logic [DATA_W-1:0] gon_data,
  output logic              glb_re,
  output logic              glb_we,
  output logic [ADDR_W-1:0] glb_addr,
  output logic [DATA_W-1:0] glb_wdata,
  input  logic [DATA_W-1:0] glb_rdata,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_ACC,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_stride;
  logic [CNT_W-1:0]    r_rem;
  logic                r_acc;
  logic [DATA_W-1:0]   r_hold;
  logic                w_hs;
  logic                w_last;

  // Psums accumulate modulo 2^DATA_W; overflow wraps silently.
  function automatic logic [DATA_W-1:0] acc_wrap(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  assign w_hs   = (r_state == S_RECV) && gon_valid;
  assign w_last = (r_rem == CNT_W'(1));

  always_comb begin
    w_next    = r_state;
    gon_ready = 1'b0;
    glb_re    = 1'b0;
    glb_we    = 1'b0;
    glb_addr  = '0;
    glb_wdata = '0;
    busy      = (r_state != S_IDLE);
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (cfg_count == '0) ? S_DONE : S_RECV;
      end
      S_RECV: begin
        gon_ready = 1'b1;
        if (w_hs) begin
          glb_addr = r_addr;
          if (r_acc) begin
            glb_re = 1'b1;
            w_next = S_ACC;
          end else begin
            glb_we    = 1'b1;
            glb_wdata = gon_data;
            w_next    = w_last ? S_DONE : S_RECV;
          end
        end
      end
      S_ACC: begin
        glb_we    = 1'b1;
        glb_addr  = r_addr;
        glb_wdata = acc_wrap(r_hold, glb_rdata);
        w_next    = w_last ? S_DONE : S_RECV;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_stride <= '0;
      r_rem    <= '0;
      r_acc    <= 1'b0;
      r_hold   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_addr   <= cfg_base;
        r_stride <= cfg_stride;
        r_rem    <= cfg_count;
        r_acc    <= cfg_acc;
      end
      // The address advances on the word's GLB write: RECV in overwrite, ACC in accumulate.
      if ((w_hs && !r_acc) || r_state == S_ACC) begin
        r_addr <= r_addr + r_stride;
        r_rem  <= r_rem - CNT_W'(1);
      end
      if (w_hs && r_acc) r_hold <= gon_data;
    end
  end

endmodule

// File: tb/tb_gon_glb_writer.sv
// Randomized bench for gon_glb_writer: a GLB memory model plus a word-level reference
// that predicts every GLB write and the final memory contents.
module tb_gon_glb_writer;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [AW-1:0] cfg_stride = '0;
  logic [CW-1:0] cfg_count = '0;
  logic          cfg_acc = 1'b0;
  logic          gon_valid = 1'b0;
  logic          gon_ready;
  logic [DW-1:0] gon_data = '0;
  logic          glb_re, glb_we;
  logic [AW-1:0] glb_addr;
  logic [DW-1:0] glb_wdata;
  logic [DW-1:0] glb_rdata;
  logic          busy, done;

  always #5 clk = ~clk;

  gon_glb_writer #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_count(cfg_count), .cfg_acc(cfg_acc),
    .gon_valid(gon_valid), .gon_ready(gon_ready), .gon_data(gon_data),
    .glb_re(glb_re), .glb_we(glb_we), .glb_addr(glb_addr), .glb_wdata(glb_wdata),
    .glb_rdata(glb_rdata), .busy(busy), .done(done)
  );

  // GLB SRAM: synchronous write, registered read data one cycle after glb_re.
  logic [DW-1:0] mem [4096];
  logic          pl_en = 1'b0;
  logic          clr = 1'b0;
  logic [AW-1:0] pl_a = '0;
  logic [DW-1:0] pl_d = '0;
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
    end else begin
      if (pl_en) mem[pl_a] <= pl_d;
      if (glb_we) mem[glb_addr] <= glb_wdata;
    end
    if (glb_re) glb_rdata <= mem[glb_addr];
  end

  logic [DW-1:0] refmem [4096];
  logic [43:0]   exp_q[$];
  logic [DW-1:0] wq[$];
  int            wr_idx = 0;
  int            n_done = 0;
  int            n_busy = 0;
  int            n_checks = 0;
  int            n_errors = 0;
  bit            last_hs = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    last_hs = gon_valid & gon_ready;
    if (glb_re) chk("re_on_handshake", 64'(last_hs), 64'd1);
    chk("re_we_exclusive", 64'(glb_re & glb_we), 64'd0);
    if (glb_we) begin
      if (wr_idx < exp_q.size()) begin
        chk("wr_addr", 64'(glb_addr), 64'(exp_q[wr_idx][43:32]));
        chk("wr_data", 64'(glb_wdata), 64'(exp_q[wr_idx][31:0]));
      end else begin
        chk("unexpected_we", 64'(wr_idx), 64'(exp_q.size()));
      end
      wr_idx++;
    end
    if (done) n_done++;
    if (busy) n_busy++;
  endtask

  task automatic tick();
    @(negedge clk);
    if (!rst) monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    refmem[a] = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic run_xfer(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                          input int cnt, input bit acc, input int stall,
                          input bit poke, input bit lat);
    int            d0, b0, guard, st;
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    logic [AW-1:0] touched[$];
    d0 = n_done;
    b0 = n_busy;
    for (int i = 0; i < cnt; i++) begin
      a = AW'((int'(base) + i * int'(stride)) % 4096);
      v = acc ? refmem[a] + wq[i] : wq[i];
      refmem[a] = v;
      exp_q.push_back({a, v});
      touched.push_back(a);
    end
    start = 1'b1; cfg_base = base; cfg_stride = stride; cfg_count = CW'(cnt); cfg_acc = acc;
    tick();
    start = 1'b0;
    cfg_base = AW'($urandom); cfg_stride = AW'($urandom); cfg_count = CW'($urandom); cfg_acc = ~acc;
    for (int i = 0; i < cnt; i++) begin
      if (i > 0 && stall != 0) begin
        st = (stall < 0) ? int'($urandom_range(3, 0)) : stall;
        gon_valid = 1'b0;
        repeat (st) tick();
      end
      if (poke && i == 1) begin
        start = 1'b1; cfg_count = CW'(0); cfg_base = AW'($urandom);
      end
      gon_valid = 1'b1;
      gon_data  = wq[i];
      guard = 0;
      do begin
        tick();
        start = 1'b0;
        guard++;
      end while (!last_hs && guard < 20);
      chk("handshake_timeout", 64'(last_hs), 64'd1);
    end
    gon_valid = 1'b0;
    guard = 0;
    while (busy && guard < 50) begin
      tick();
      guard++;
    end
    chk("busy_cleared", 64'(busy), 64'd0);
    chk("done_pulses", 64'(n_done - d0), 64'd1);
    if (lat) chk("busy_cycles", 64'(n_busy - b0), 64'(acc ? 2 * cnt + 1 : cnt + 1));
    chk("write_count", 64'(wr_idx), 64'(exp_q.size()));
    foreach (touched[k]) chk("mem_final", 64'(mem[touched[k]]), 64'(refmem[touched[k]]));
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) refmem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({glb_re, glb_we, gon_ready, busy, done, glb_addr, glb_wdata}), 64'd0);
    rst = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("idle_outputs", 64'({gon_ready, busy, done}), 64'd0);

    // Overwrite stream, back-to-back.
    wq = {32'd1, 32'd2, 32'd3, 32'd4};
    run_xfer(12'h010, 12'd1, 4, 1'b0, 0, 1'b0, 1'b1);

    // Accumulate with stride 2.
    preload(12'h100, 32'd10);
    preload(12'h102, 32'd20);
    wq = {32'd5, 32'd7};
    run_xfer(12'h100, 12'd2, 2, 1'b1, 0, 1'b0, 1'b1);
    chk("acc_0x100", 64'(mem[12'h100]), 64'd15);
    chk("acc_0x102", 64'(mem[12'h102]), 64'd27);

    // Stalls between words and address wrap.
    wq = {32'hAAAA_0001, 32'hAAAA_0002};
    run_xfer(12'hFFF, 12'd1, 2, 1'b0, 3, 1'b0, 1'b0);
    chk("wrap_0x000", 64'(mem[12'h000]), 64'hAAAA_0002);

    // Zero-length transfer.
    wq.delete();
    run_xfer(12'h123, 12'd1, 0, 1'b0, 0, 1'b0, 1'b1);

    // Start pulsed mid-transfer must not disturb the running one.
    wq = {32'd11, 32'd12, 32'd13, 32'd14, 32'd15};
    run_xfer(12'h200, 12'd3, 5, 1'b0, 0, 1'b1, 1'b0);

    // Accumulate into one location with stride 0.
    preload(12'h300, 32'd0);
    wq = {32'd1, 32'd1, 32'd1};
    run_xfer(12'h300, 12'd0, 3, 1'b1, 0, 1'b0, 1'b1);
    chk("stride0_sum", 64'(mem[12'h300]), 64'd3);

    // Accumulate overflow wraps.
    preload(12'h400, 32'hFFFF_FFFF);
    wq = {32'd2};
    run_xfer(12'h400, 12'd1, 1, 1'b1, 0, 1'b0, 1'b1);
    chk("acc_overflow", 64'(mem[12'h400]), 64'd1);

    // Asynchronous reset while in ACC.
    preload(12'h500, 32'd100);
    n = n_done;
    start = 1'b1; cfg_base = 12'h500; cfg_stride = 12'd1; cfg_count = 16'd2; cfg_acc = 1'b1;
    tick();
    start = 1'b0;
    gon_valid = 1'b1; gon_data = 32'd9;
    tick();
    gon_valid = 1'b0;
    chk("in_acc_before_reset", 64'({busy, gon_ready}), 64'h2);
    #1 rst = 1'b1;
    #1 chk("reset_mid_acc_outputs",
           64'({glb_re, glb_we, gon_ready, busy, done, glb_addr, glb_wdata}), 64'd0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("no_done_after_reset", 64'(n_done - n), 64'd0);
    chk("idle_after_reset", 64'(busy), 64'd0);
    chk("mem_untouched_by_reset", 64'(mem[12'h500]), 64'd100);
    wq = {32'd9, 32'd3};
    run_xfer(12'h500, 12'd1, 2, 1'b1, 0, 1'b0, 1'b1);

    // Randomized transfers.
    for (int t = 0; t < 24; t++) begin
      logic [AW-1:0] b, s;
      int            c, stl;
      bit            ac;
      b   = AW'($urandom);
      s   = ($urandom_range(3, 0) == 0) ? AW'($urandom) : AW'($urandom_range(3, 0));
      c   = int'($urandom_range(6, 0));
      ac  = 1'($urandom);
      stl = ($urandom_range(1, 0) == 0) ? 0 : -1;
      wq.delete();
      for (int i = 0; i < c; i++)
        wq.push_back(($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15, 0))
                                                  : 32'($urandom));
      run_xfer(b, s, c, ac, stl, 1'($urandom_range(3, 0) == 0), stl == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
